// File: rtl/usb_attach_ctrl_pkg.sv
// Shared types and timing helpers for the USB bus-attach sequencer.
`timescale 1ns/1ps
package usb_attach_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_ATTACHED,
        ST_BUS_RESET,
        ST_DETACH
    } attach_state_t;

    localparam int DEF_CLK_FREQ_HZ    = 48_000_000;
    localparam int DEF_LOCK_SETTLE_US = 100;
    localparam int DEF_BUS_RESET_US   = 3;
    localparam int DEF_DETACH_MIN_US  = 10_000;
    localparam int DEF_SUSPEND_US     = 3_000;

    function automatic int us_to_cycles(input int clk_freq_hz, input int us);
        return (clk_freq_hz / 1_000_000) * us;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_attach_sync.sv
// Parametrised-width two-flop synchroniser with async active-low reset.
`timescale 1ns/1ps
module usb_attach_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usb_attach_ctrl.sv
// USB attach/reset sequencer: PLL-lock settle, D+ pull-up, bus-reset and soft-detach handling.
// Optional idle-J suspend detection is built when USB_SUSPEND_DETECT_EN is defined.
`timescale 1ns/1ps
module usb_attach_ctrl
    import usb_attach_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int LOCK_SETTLE_US = DEF_LOCK_SETTLE_US,
    parameter int BUS_RESET_US   = DEF_BUS_RESET_US,
    parameter int DETACH_MIN_US  = DEF_DETACH_MIN_US,
    parameter int SUSPEND_US     = DEF_SUSPEND_US
) (
    input  logic clk48,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic usb_dp_in,
    input  logic usb_dn_in,
    input  logic soft_detach,
    output logic usb_pullup,
    output logic dev_rst_n,
    output logic bus_reset_pulse,
    output logic attached,
    output logic suspended
);

    localparam int LOCK_SETTLE_CYC = us_to_cycles(CLK_FREQ_HZ, LOCK_SETTLE_US);
    localparam int BUS_RESET_CYC   = us_to_cycles(CLK_FREQ_HZ, BUS_RESET_US);
    localparam int DETACH_MIN_CYC  = us_to_cycles(CLK_FREQ_HZ, DETACH_MIN_US);
    localparam int CNT_W  = $clog2(max2(max2(LOCK_SETTLE_CYC, DETACH_MIN_CYC), 2));
    localparam int SE0_W  = $clog2(max2(BUS_RESET_CYC, 2));

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_MIN_CYC - 1);
    localparam logic [SE0_W-1:0] SE0_LAST    = SE0_W'(BUS_RESET_CYC - 1);

    attach_state_t    state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [SE0_W-1:0] se0_cnt, se0_cnt_next;
    logic [2:0]       sync_q;
    logic             lock_s, dp_s, dn_s, se0;
    logic             pullup_d, dev_rst_n_d, pulse_d, suspended_d;

    usb_attach_sync #(.WIDTH(3)) u_sync (
        .clk   (clk48),
        .rst_n (rst_n),
        .d     ({pll_locked, usb_dp_in, usb_dn_in}),
        .q     (sync_q)
    );

    assign {lock_s, dp_s, dn_s} = sync_q;
    assign se0 = !dp_s && !dn_s;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            se0_cnt <= '0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            se0_cnt <= se0_cnt_next;
        end
    end

    // Lock loss outranks soft detach, which outranks line/timeout events.
    always_comb begin
        next_state = state;
        if (!lock_s) begin
            next_state = ST_WAIT_LOCK;
        end else begin
            unique case (state)
                ST_WAIT_LOCK: next_state = ST_SETTLE;
                ST_SETTLE:    if (cnt == LOCK_LAST) next_state = ST_ATTACHED;
                ST_ATTACHED: begin
                    if (soft_detach)                    next_state = ST_DETACH;
                    else if (se0 && se0_cnt == SE0_LAST) next_state = ST_BUS_RESET;
                end
                ST_BUS_RESET: begin
                    if (soft_detach) next_state = ST_DETACH;
                    else if (!se0)   next_state = ST_ATTACHED;
                end
                ST_DETACH:    if (cnt == DETACH_LAST && !soft_detach) next_state = ST_SETTLE;
                default:      next_state = ST_WAIT_LOCK;
            endcase
        end

        cnt_next = '0;
        if (next_state == state) begin
            if (state == ST_SETTLE)
                cnt_next = cnt + 1'b1;
            else if (state == ST_DETACH)
                cnt_next = (cnt == DETACH_LAST) ? cnt : cnt + 1'b1;
        end

        se0_cnt_next = '0;
        if (state == ST_ATTACHED && next_state == ST_ATTACHED && se0)
            se0_cnt_next = se0_cnt + 1'b1;
    end

    always_comb begin
        pullup_d    = (next_state == ST_ATTACHED) || (next_state == ST_BUS_RESET);
        dev_rst_n_d = (next_state == ST_ATTACHED);
        pulse_d     = (next_state == ST_BUS_RESET) && (state != ST_BUS_RESET);
    end

`ifdef USB_SUSPEND_DETECT_EN
    localparam int SUSPEND_CYC = us_to_cycles(CLK_FREQ_HZ, SUSPEND_US);
    localparam int J_W         = $clog2(SUSPEND_CYC + 1);
    localparam logic [J_W-1:0] J_FULL = J_W'(SUSPEND_CYC);

    logic [J_W-1:0] j_cnt, j_cnt_next;
    logic           idle_j;

    assign idle_j = dp_s && !dn_s;

    // The idle-J count saturates at the suspend threshold so suspended holds steady.
    always_comb begin
        j_cnt_next = '0;
        if (state == ST_ATTACHED && next_state == ST_ATTACHED && idle_j)
            j_cnt_next = (j_cnt == J_FULL) ? j_cnt : j_cnt + 1'b1;
        suspended_d = (j_cnt_next == J_FULL);
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) j_cnt <= '0;
        else        j_cnt <= j_cnt_next;
    end
`else
    assign suspended_d = 1'b0;
`endif

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            usb_pullup      <= 1'b0;
            dev_rst_n       <= 1'b0;
            bus_reset_pulse <= 1'b0;
            attached        <= 1'b0;
            suspended       <= 1'b0;
        end else begin
            usb_pullup      <= pullup_d;
            dev_rst_n       <= dev_rst_n_d;
            bus_reset_pulse <= pulse_d;
            attached        <= pullup_d;
            suspended       <= suspended_d;
        end
    end

endmodule

// File: doc/usb_attach_ctrl.md
# usb_attach_ctrl

Bus-attach and reset sequencer between the clock generator and the USB device controller in the top level. Waits for PLL lock and a settle interval, then drives the D+ pull-up, detects host bus reset (SE0) and supports software-requested detach with a guaranteed minimum disconnect time. It provides a clean synchronous reset to the device controller, replacing the unconditional pull-up drive of the previous top level.

## Interface
Parameters:
- CLK_FREQ_HZ, 48_000_000, frequency of clk48; must be an integer multiple of 1 MHz.
- LOCK_SETTLE_US, 100, delay after PLL lock before the pull-up is enabled.
- BUS_RESET_US, 3, consecutive SE0 time treated as bus reset.
- DETACH_MIN_US, 10_000, minimum pull-up-off time on a soft detach.
- SUSPEND_US, 3_000, idle-J time treated as suspend (only used with USB_SUSPEND_DETECT_EN).

Ports:
- clk48 in 1: 48 MHz system clock.
- rst_n in 1: reset; asynchronous, active-low.
- pll_locked in 1: PLL lock indicator; asynchronous to clk48.
- usb_dp_in in 1: raw D+ line level; asynchronous.
- usb_dn_in in 1: raw D- line level; asynchronous.
- soft_detach in 1: level request to disconnect; synchronous to clk48.
- usb_pullup out 1: D+ pull-up enable.
- dev_rst_n out 1: synchronous active-low reset to the device controller.
- bus_reset_pulse out 1: one-cycle strobe when a bus reset is detected.
- attached out 1: high in ATTACHED and BUS_RESET.
- suspended out 1: bus suspended.

## Operation
- Derived constant: X_CYC = (CLK_FREQ_HZ/1_000_000)*X_US. A single shared counter is sized to $clog2 of the largest X_CYC.
- pll_locked, usb_dp_in and usb_dn_in pass through a 2-FF synchroniser. All FSM decisions use the synchronised values.
- SE0 means dp=0 and dn=0. Idle J means dp=1 and dn=0.
- WAIT_LOCK: usb_pullup=0, dev_rst_n=0. Moves to SETTLE when synchronised lock=1; the counter clears.
- SETTLE: the counter increments each cycle. At counter==LOCK_SETTLE_CYC-1 the FSM moves to ATTACHED.
- ATTACHED: usb_pullup=1, dev_rst_n=1.
  - The SE0 counter counts consecutive SE0 cycles and clears on any non-SE0 cycle.
  - When it reaches BUS_RESET_CYC the FSM moves to BUS_RESET.
- BUS_RESET:
  - bus_reset_pulse=1 for the entry cycle only.
  - usb_pullup=1, dev_rst_n=0.
  - The first non-SE0 cycle returns the FSM to ATTACHED, with the SE0 counter cleared.
- DETACH: usb_pullup=0, dev_rst_n=0. The counter runs to DETACH_MIN_CYC-1 and then saturates. The FSM moves to SETTLE once the counter is saturated and soft_detach=0.
- Transition priority in every state, highest first:
  1. Lock loss: synchronised lock=0 sends the FSM to WAIT_LOCK.
  2. soft_detach=1 in ATTACHED or BUS_RESET sends the FSM to DETACH, with the counter cleared.
  3. SE0 / timeout transitions.
- soft_detach is ignored in WAIT_LOCK and SETTLE; it is not latched.
- Reset mid-operation: all state returns to the reset values immediately, asynchronously.

## Timing
- Reset values:
  - FSM=WAIT_LOCK, counters=0, synchronisers=0.
  - usb_pullup=0, dev_rst_n=0, bus_reset_pulse=0, attached=0, suspended=0.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state change.
- Input latency is 2 cycles through the synchroniser.
- pll_locked rising to usb_pullup=1 takes 3 + LOCK_SETTLE_CYC cycles.
- SE0 onset on the pins to bus_reset_pulse takes 2 + BUS_RESET_CYC cycles. SE0 lasting BUS_RESET_CYC-1 cycles has no effect.
- SE0 end to dev_rst_n=1 takes 3 cycles.
- soft_detach=1 to usb_pullup=0 takes 1 cycle.

## Configuration
- USB_SUSPEND_DETECT_EN defined:
  - In ATTACHED, a counter counts consecutive idle-J cycles and clears on any other cycle.
  - suspended=1 once the count reaches SUSPEND_CYC.
  - suspended clears on the first non-J cycle or on leaving ATTACHED.
  - dev_rst_n is unaffected by suspend.
- USB_SUSPEND_DETECT_EN undefined: no idle-J counter is built, and suspended is tied to 0 (the port remains).

## Structure
- config_pkg gains:
  - the FSM state enum;
  - a us_to_cycles function;
  - the default timing constants.
- One sub-module, usb_attach_sync: a parametrised-width 2-FF synchroniser with async active-low reset, instantiated once for 3 bits.
- Top-level change: instantiated in top; usb_pullup replaces the device controller's USB_PULLUP drive, and dev_rst_n resets the device controller.

## Test plan
- Power-up: rst_n released, pll_locked rises at cycle 10 -> usb_pullup and dev_rst_n go high at cycle 4813, attached=1.
- Bus reset: SE0 held 144 cycles -> one bus_reset_pulse, dev_rst_n=0 until 3 cycles after SE0 ends. SE0 held 143 cycles -> no pulse.
- Soft detach: soft_detach pulsed 5 cycles while ATTACHED -> usb_pullup=0 for exactly 480000+4800 cycles, then reattach.
- Priority: pll_locked falls in the same cycle soft_detach rises, mid BUS_RESET -> WAIT_LOCK, pullup=0, no reattach until relock.
- Suspend (macro on): idle J for 144000 cycles -> suspended=1; one SE0 cycle -> suspended=0. Macro off -> suspended stays 0.
- Async reset: rst_n low mid-DETACH -> all outputs at their reset values before the next clk48 edge.
